clock_switch_ctrl: RTL and testbench
====================================

Name: clock_switch_ctrl

Overview:
Sequencer that owns CPU clock selection: turns the speed switch and JP2/JP3/JP4 into safe clock changes. Drives the two 4-input dynamic clock selectors' one-hot selects, the bank mux (dcs0/dcs1) and the stock/turbo mux. A change is applied only after the inputs are debounced and the 68k bus is idle, with the CPU parked on C7M for the whole reselect. Runs in the C7M domain.

Parameters:
DEBOUNCE_CYCLES, 70000, cycles the requested code must stay stable before acting (10 ms at 7.09 MHz); counter width 17 bits
IDLE_CYCLES, 4, consecutive bus-idle cycles required before parking
PARK_CYCLES, 4, cycles held on C7M before reprogramming selectors
SETTLE_CYCLES, 8, cycles after reprogramming before turbo is re-enabled

Ports:
C7M  input  1  system clock; all logic on posedge
RESET  input  1  synchronous, active-high reset
CPU_SPEED_SWITCH  input  1  async; 1 = stock C7M, 0 = turbo requested
JP2  input  1  async; speed select bit 2 (bank)
JP3  input  1  async; speed select bit 1
JP4  input  1  async; speed select bit 0
AS_CPU_n  input  1  async CPU address strobe, active low
DTACK_CPU_n  input  1  async DTACK, active low
CLKSEL0  output  4  one-hot select for bank-0 DCS (C7M/C14M/C21M/C28M)
CLKSEL1  output  4  one-hot select for bank-1 DCS (C33M/C42M/C50M/OSC)
BANK_SEL  output  1  0 = bank 0 output, 1 = bank 1 output
TURBO_EN  output  1  1 = CPU clock from selected bank, 0 = C7M
BUSY  output  1  high whenever the FSM is not in IDLE
DONE  output  1  one-cycle pulse when a change completes
CUR_CODE  output  4  applied code {turbo, sel[2:0]}

Behaviour:
- Every async input goes through a 2-FF synchroniser (2-cycle latency). Requested code REQ = {~spd_s, jp2_s, jp3_s, jp4_s}.
- Reset values: CLKSEL0=0001, CLKSEL1=0001, BANK_SEL=0, TURBO_EN=0, BUSY=0, DONE=0, CUR_CODE=0000. State is IDLE and all counters are 0. Reset mid-sequence aborts immediately to these values.
- IDLE: if REQ != CUR_CODE, latch TGT=REQ, clear the counter, go to DEBOUNCE.
- DEBOUNCE: counter increments while REQ==TGT.
  - If REQ changes and differs from CUR_CODE: TGT=REQ and the counter restarts.
  - If REQ returns to CUR_CODE: go to IDLE, no outputs change.
  - When the counter reaches DEBOUNCE_CYCLES-1: go to WAIT_BUS.
- WAIT_BUS: counts consecutive cycles with as_s=1 and dtack_s=1; any low resets the count.
  - At IDLE_CYCLES: go to PARK.
  - If REQ != TGT in this state: go back to DEBOUNCE (same rules as above).
  - No timeout; waits indefinitely.
- PARK: TURBO_EN=0 from the entry cycle. Hold PARK_CYCLES cycles, then go to SELECT. REQ is ignored from PARK onward.
- SELECT: single cycle.
  - If TGT[2]=0: CLKSEL0 = 1<<TGT[1:0].
  - If TGT[2]=1: CLKSEL1 = 1<<TGT[1:0].
  - The other bank's select holds its value. BANK_SEL=TGT[2].
  - Go to SETTLE.
- SETTLE: hold SETTLE_CYCLES cycles. On exit: TURBO_EN=TGT[3], CUR_CODE=TGT, DONE=1 for one cycle, go to IDLE.
- A new REQ difference seen in IDLE after DONE starts a fresh sequence; there is no back-to-back skip.
- The full sequence runs even when only the turbo bit changes, including 1->0 (parking is harmless).
- Invariants:
  - CLKSEL0 and CLKSEL1 are always exactly one-hot.
  - CLKSEL*/BANK_SEL change only while TURBO_EN=0 and the FSM is in SELECT.
  - TURBO_EN never goes 0->1 outside the SETTLE exit.
- Minimum latency from a stable input change to DONE = 2 + DEBOUNCE_CYCLES + IDLE_CYCLES + PARK_CYCLES + 1 + SETTLE_CYCLES cycles, plus a few cycles of FSM entry overhead. The bench must measure the exact figure.

Test Plan:
- Params 8/4/4/8. Reset with SPEED=0, JP=011, bus idle -> TURBO_EN=0 throughout; CLKSEL0 0001->1000 in SELECT; TURBO_EN=1 and CUR_CODE=1011 with DONE pulse; CLKSEL1 stays 0001.
- From CUR_CODE=1011, set JP=110 -> TURBO_EN drops in PARK; CLKSEL1=0100, BANK_SEL=1, CLKSEL0 stays 1000; DONE; CUR_CODE=1110.
- Toggle JP4 every 3 cycles for 40 cycles, then restore the original value -> BUSY returns to 0 with no DONE and no output changes.
- Stable change while AS_CPU_n pulses low once every 3 cycles -> FSM stays in WAIT_BUS, TURBO_EN unchanged. Release AS for 4 cycles -> PARK follows.
- Set SPEED=1 with the same JP -> full sequence; TURBO_EN=0 at end; CLKSEL unchanged; CUR_CODE[3]=0; DONE pulses.
- Assert RESET during SETTLE -> next cycle all outputs equal reset values, state IDLE; after release the pending REQ is re-sequenced from DEBOUNCE.

Source files
------------

// File: rtl/clock_switch_ctrl.sv
// CPU clock selection sequencer. Debounces the speed switch and the JP2/JP3/JP4
// jumpers, waits for an idle 68k bus, parks the CPU on C7M, reprograms the two
// dynamic clock selectors and the bank mux, then re-enables turbo.
module clock_switch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 70000,
  parameter int IDLE_CYCLES     = 4,
  parameter int PARK_CYCLES     = 4,
  parameter int SETTLE_CYCLES   = 8
) (
  input  logic       C7M,
  input  logic       RESET,
  input  logic       CPU_SPEED_SWITCH,
  input  logic       JP2,
  input  logic       JP3,
  input  logic       JP4,
  input  logic       AS_CPU_n,
  input  logic       DTACK_CPU_n,
  output logic [3:0] CLKSEL0,
  output logic [3:0] CLKSEL1,
  output logic       BANK_SEL,
  output logic       TURBO_EN,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] CUR_CODE
);

  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PARK_LAST   = CNT_W'(PARK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DEBOUNCE, ST_WAIT_BUS, ST_PARK, ST_SELECT, ST_SETTLE
  } state_t;

  state_t           state, state_next;
  logic [3:0]       tgt, tgt_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [5:0]       sync_p0, sync_p1;
  logic [3:0]       req;
  logic             bus_idle;

  // Map a two-bit clock index onto a one-hot selector code.
  function automatic logic [3:0] to_onehot(input logic [1:0] idx);
    to_onehot = 4'b0001 << idx;
  endfunction

  // Stage p0/p1: two-flop synchronisers for every asynchronous input
  always_ff @(posedge C7M) begin
    sync_p0 <= {CPU_SPEED_SWITCH, JP2, JP3, JP4, AS_CPU_n, DTACK_CPU_n};
    sync_p1 <= sync_p0;
  end

  assign req      = {~sync_p1[5], sync_p1[4], sync_p1[3], sync_p1[2]};
  assign bus_idle = sync_p1[1] & sync_p1[0];

  // State register together with the latched target code and shared counter
  always_ff @(posedge C7M) begin
    if (RESET) begin
      state <= ST_IDLE;
      tgt   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      tgt   <= tgt_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; a request change before parking restarts the debounce
  always_comb begin
    state_next = state;
    tgt_next   = tgt;
    cnt_next   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (req != CUR_CODE) begin
          tgt_next   = req;
          cnt_next   = '0;
          state_next = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE, ST_WAIT_BUS: begin
        if (req != tgt) begin
          cnt_next = '0;
          if (req == CUR_CODE) begin
            state_next = ST_IDLE;
          end else begin
            tgt_next   = req;
            state_next = ST_DEBOUNCE;
          end
        end else if (state == ST_DEBOUNCE) begin
          if (cnt == DEB_LAST) begin
            cnt_next   = '0;
            state_next = ST_WAIT_BUS;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else if (bus_idle) begin
          if (cnt == IDLE_LAST) begin
            cnt_next   = '0;
            state_next = ST_PARK;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else begin
          cnt_next = '0;
        end
      end
      ST_PARK: begin
        if (cnt == PARK_LAST) begin
          cnt_next   = '0;
          state_next = ST_SELECT;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_SELECT: begin
        cnt_next   = '0;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output comb: busy whenever a sequence is in flight
  always_comb begin
    BUSY = (state != ST_IDLE);
  end

  // Clock-control registers; updated on transitions so each value is already
  // visible in the first cycle of the state it belongs to
  always_ff @(posedge C7M) begin
    if (RESET) begin
      CLKSEL0  <= 4'b0001;
      CLKSEL1  <= 4'b0001;
      BANK_SEL <= 1'b0;
      TURBO_EN <= 1'b0;
      DONE     <= 1'b0;
      CUR_CODE <= 4'b0000;
    end else begin
      DONE <= 1'b0;
      if (state == ST_WAIT_BUS && state_next == ST_PARK) begin
        TURBO_EN <= 1'b0;
      end
      if (state == ST_PARK && state_next == ST_SELECT) begin
        if (tgt[2]) begin
          CLKSEL1 <= to_onehot(tgt[1:0]);
        end else begin
          CLKSEL0 <= to_onehot(tgt[1:0]);
        end
        BANK_SEL <= tgt[2];
      end
      if (state == ST_SETTLE && state_next == ST_IDLE) begin
        TURBO_EN <= tgt[3];
        CUR_CODE <= tgt;
        DONE     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Directed bench for clock_switch_ctrl with short debounce/idle/park/settle
// times (8/4/4/8) so every sequence completes in a few dozen cycles.
module tb_clock_switch_ctrl;

  logic       C7M = 1'b0;
  logic       RESET;
  logic       CPU_SPEED_SWITCH, JP2, JP3, JP4, AS_CPU_n, DTACK_CPU_n;
  logic [3:0] CLKSEL0, CLKSEL1, CUR_CODE;
  logic       BANK_SEL, TURBO_EN, BUSY, DONE;
  logic [15:0] outs;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] RESET_VAL = 16'b0001_0001_0_0_0_0_0000;

  clock_switch_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .IDLE_CYCLES    (4),
    .PARK_CYCLES    (4),
    .SETTLE_CYCLES  (8)
  ) dut (
    .C7M             (C7M),
    .RESET           (RESET),
    .CPU_SPEED_SWITCH(CPU_SPEED_SWITCH),
    .JP2             (JP2),
    .JP3             (JP3),
    .JP4             (JP4),
    .AS_CPU_n        (AS_CPU_n),
    .DTACK_CPU_n     (DTACK_CPU_n),
    .CLKSEL0         (CLKSEL0),
    .CLKSEL1         (CLKSEL1),
    .BANK_SEL        (BANK_SEL),
    .TURBO_EN        (TURBO_EN),
    .BUSY            (BUSY),
    .DONE            (DONE),
    .CUR_CODE        (CUR_CODE)
  );

  assign outs = {CLKSEL0, CLKSEL1, BANK_SEL, TURBO_EN, BUSY, DONE, CUR_CODE};

  always #5 C7M = ~C7M;

  task automatic tick();
    @(posedge C7M);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    CPU_SPEED_SWITCH = 1'b0;
    JP2 = 1'b0; JP3 = 1'b1; JP4 = 1'b1;
    AS_CPU_n = 1'b1; DTACK_CPU_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (outs !== RESET_VAL) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs, RESET_VAL);
    end
  endtask

  task automatic test_first_change();
    int n = 0;
    int sel_cyc = -1;
    bit sel_ok = 1'b0;
    bit early_turbo = 1'b0;
    logic [3:0] prev0 = CLKSEL0;
    RESET = 1'b0;
    while (DONE !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (DONE !== 1'b1 && TURBO_EN !== 1'b0) early_turbo = 1'b1;
      if (CLKSEL0 !== prev0 && sel_cyc < 0) begin
        sel_cyc = n;
        sel_ok  = (TURBO_EN === 1'b0 && BUSY === 1'b1);
      end
      prev0 = CLKSEL0;
    end
    checks++;
    if (n !== 26) begin errors++; $display("FAIL first_done_latency: got %0d expected %0d", n, 26); end
    checks++;
    if (sel_cyc !== 17) begin errors++; $display("FAIL first_select_cycle: got %0d expected %0d", sel_cyc, 17); end
    checks++;
    if (sel_ok !== 1'b1) begin errors++; $display("FAIL first_select_parked: got %0d expected %0d", sel_ok, 1); end
    checks++;
    if (early_turbo !== 1'b0) begin errors++; $display("FAIL first_turbo_early: got %0d expected %0d", early_turbo, 0); end
    checks++;
    if (outs !== 16'b1000_0001_0_1_0_1_1011) begin
      errors++; $display("FAIL first_done_outputs: got %b expected %b", outs, 16'b1000_0001_0_1_0_1_1011);
    end
    tick();
    checks++;
    if ({BUSY, DONE} !== 2'b00) begin errors++; $display("FAIL first_done_pulse: got %b expected %b", {BUSY, DONE}, 2'b00); end
  endtask

  task automatic test_bank1();
    int n = 0;
    int busy_cyc = -1;
    int drop_cyc = -1;
    int sel_cyc = -1;
    bit sel_ok = 1'b0;
    logic [3:0] prev1 = CLKSEL1;
    JP2 = 1'b1; JP3 = 1'b1; JP4 = 1'b0;
    while (DONE !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (BUSY === 1'b1 && busy_cyc < 0) busy_cyc = n;
      if (TURBO_EN === 1'b0 && drop_cyc < 0) drop_cyc = n;
      if (CLKSEL1 !== prev1 && sel_cyc < 0) begin
        sel_cyc = n;
        sel_ok  = (TURBO_EN === 1'b0 && BUSY === 1'b1 && BANK_SEL === 1'b1);
      end
      prev1 = CLKSEL1;
    end
    checks++;
    if (busy_cyc !== 3) begin errors++; $display("FAIL bank1_busy_cycle: got %0d expected %0d", busy_cyc, 3); end
    checks++;
    if (drop_cyc !== 15) begin errors++; $display("FAIL bank1_park_cycle: got %0d expected %0d", drop_cyc, 15); end
    checks++;
    if (sel_cyc !== 19) begin errors++; $display("FAIL bank1_select_cycle: got %0d expected %0d", sel_cyc, 19); end
    checks++;
    if (sel_ok !== 1'b1) begin errors++; $display("FAIL bank1_select_parked: got %0d expected %0d", sel_ok, 1); end
    checks++;
    if (n !== 28) begin errors++; $display("FAIL bank1_done_latency: got %0d expected %0d", n, 28); end
    checks++;
    if (outs !== 16'b1000_0100_1_1_0_1_1110) begin
      errors++; $display("FAIL bank1_done_outputs: got %b expected %b", outs, 16'b1000_0100_1_1_0_1_1110);
    end
    tick();
  endtask

  task automatic test_glitch();
    localparam logic [14:0] HOLD = {4'b1000, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b1110};
    bit busy_seen = 1'b0;
    bit done_seen = 1'b0;
    bit changed = 1'b0;
    for (int i = 0; i < 52; i++) begin
      if (i < 40 && (i % 3) == 0) JP4 = ~JP4;
      if (i == 40) JP4 = 1'b0;
      tick();
      if (BUSY === 1'b1) busy_seen = 1'b1;
      if (DONE !== 1'b0) done_seen = 1'b1;
      if ({CLKSEL0, CLKSEL1, BANK_SEL, TURBO_EN, DONE, CUR_CODE} !== HOLD) changed = 1'b1;
    end
    checks++;
    if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen: got %0d expected %0d", busy_seen, 1); end
    checks++;
    if (done_seen !== 1'b0) begin errors++; $display("FAIL glitch_no_done: got %0d expected %0d", done_seen, 0); end
    checks++;
    if (changed !== 1'b0) begin errors++; $display("FAIL glitch_outputs_held: got %0d expected %0d", changed, 0); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %0d expected %0d", BUSY, 0); end
  endtask

  task automatic test_bus_busy();
    int n = 0;
    int drop_cyc = -1;
    bit turbo_low = 1'b0;
    bit done_seen = 1'b0;
    JP4 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      AS_CPU_n    = ((i % 6) == 2) ? 1'b0 : 1'b1;
      DTACK_CPU_n = ((i % 6) == 5) ? 1'b0 : 1'b1;
      tick();
      if (TURBO_EN !== 1'b1) turbo_low = 1'b1;
      if (DONE !== 1'b0) done_seen = 1'b1;
    end
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL bus_wait_busy: got %0d expected %0d", BUSY, 1); end
    checks++;
    if (turbo_low !== 1'b0) begin errors++; $display("FAIL bus_wait_turbo_held: got %0d expected %0d", turbo_low, 0); end
    checks++;
    if (done_seen !== 1'b0) begin errors++; $display("FAIL bus_wait_no_done: got %0d expected %0d", done_seen, 0); end
    AS_CPU_n = 1'b1;
    DTACK_CPU_n = 1'b1;
    while (DONE !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (TURBO_EN === 1'b0 && drop_cyc < 0) drop_cyc = n;
    end
    checks++;
    if (drop_cyc !== 6) begin errors++; $display("FAIL bus_release_park: got %0d expected %0d", drop_cyc, 6); end
    checks++;
    if (n !== 19) begin errors++; $display("FAIL bus_release_done: got %0d expected %0d", n, 19); end
    checks++;
    if (outs !== 16'b1000_1000_1_1_0_1_1111) begin
      errors++; $display("FAIL bus_done_outputs: got %b expected %b", outs, 16'b1000_1000_1_1_0_1_1111);
    end
    tick();
  endtask

  task automatic test_stock();
    int n = 0;
    int drop_cyc = -1;
    bit sel_changed = 1'b0;
    CPU_SPEED_SWITCH = 1'b1;
    while (DONE !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (TURBO_EN === 1'b0 && drop_cyc < 0) drop_cyc = n;
      if ({CLKSEL0, CLKSEL1, BANK_SEL} !== 9'b1000_1000_1) sel_changed = 1'b1;
    end
    checks++;
    if (n !== 28) begin errors++; $display("FAIL stock_done_latency: got %0d expected %0d", n, 28); end
    checks++;
    if (drop_cyc !== 15) begin errors++; $display("FAIL stock_park_cycle: got %0d expected %0d", drop_cyc, 15); end
    checks++;
    if (sel_changed !== 1'b0) begin errors++; $display("FAIL stock_sel_held: got %0d expected %0d", sel_changed, 0); end
    checks++;
    if (outs !== 16'b1000_1000_1_0_0_1_0111) begin
      errors++; $display("FAIL stock_done_outputs: got %b expected %b", outs, 16'b1000_1000_1_0_0_1_0111);
    end
    tick();
    checks++;
    if (DONE !== 1'b0) begin errors++; $display("FAIL stock_done_pulse: got %0d expected %0d", DONE, 0); end
  endtask

  task automatic test_reset_settle();
    int n = 0;
    CPU_SPEED_SWITCH = 1'b0;
    repeat (22) tick();
    checks++;
    if ({BUSY, TURBO_EN, DONE} !== 3'b100) begin
      errors++; $display("FAIL settle_state: got %b expected %b", {BUSY, TURBO_EN, DONE}, 3'b100);
    end
    RESET = 1'b1;
    tick();
    checks++;
    if (outs !== RESET_VAL) begin
      errors++; $display("FAIL settle_reset_outputs: got %b expected %b", outs, RESET_VAL);
    end
    RESET = 1'b0;
    while (DONE !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 26) begin errors++; $display("FAIL resequence_latency: got %0d expected %0d", n, 26); end
    checks++;
    if (outs !== 16'b0001_1000_1_1_0_1_1111) begin
      errors++; $display("FAIL resequence_outputs: got %b expected %b", outs, 16'b0001_1000_1_1_0_1_1111);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_first_change();
    test_bank1();
    test_glitch();
    test_bus_busy();
    test_stock();
    test_reset_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
